// File: rtl/arm_pkg.sv
// Shared definitions for the ARM decode stage: ALU command codes, instruction
// field encodings, condition codes, status-bit positions and the ID/EX
// register layout.
package arm_pkg;

  // ALU commands driven to the execute stage
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  // Data-processing opcodes, instruction bits [24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Instruction class, bits [27:26]
  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  // Condition field, bits [31:28]
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // Bit positions inside the {N,Z,C,V} status word
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  // Execute-stage controls; zeroing this struct yields a bubble
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  // Operand and field payload carried across the ID/EX boundary
  typedef struct packed {
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [31:0] pc;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
  } idex_data_t;

  // True when the condition field is satisfied by the current flags
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
    logic n, z, c, v, pass;
    n = sr[SR_N];
    z = sr[SR_Z];
    c = sr[SR_C];
    v = sr[SR_V];
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/register_file.sv
// Two-read / one-write register file for R0..R(NUM_REGS-1). Addresses at or
// above NUM_REGS read as the PC; writes there are dropped. A read that hits
// the register being written this cycle sees the new value.
module register_file
  import arm_pkg::*;
#(
  parameter int NUM_REGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [3:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_raddr1,
  input  logic [3:0]  i_raddr2,
  input  logic [31:0] i_pc,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  localparam logic [3:0] PC_ADDR = 4'(NUM_REGS);

  logic [31:0] r_regs [NUM_REGS];
  logic        w_wr_hit;

  assign w_wr_hit = i_we && (i_waddr < PC_ADDR);

  // Register storage: cleared on reset, written on the rising edge
  // NOTE: the array is small and architecturally defined as zero after reset,
  // so it is flops with an async clear rather than an inferred RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_hit) begin
      // NOTE: non-blocking assignment keeps every flop update on the edge
      // independent of evaluation order between always_ff blocks.
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read port 1: PC alias, then write-through, then stored value
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch forms.
    o_rdata1 = '0;
    if (i_raddr1 >= PC_ADDR)                  o_rdata1 = i_pc;
    else if (w_wr_hit && i_waddr == i_raddr1) o_rdata1 = i_wdata;
    else                                      o_rdata1 = r_regs[i_raddr1];
  end

  // Read port 2: same priority as port 1
  always_comb begin
    o_rdata2 = '0;
    if (i_raddr2 >= PC_ADDR)                  o_rdata2 = i_pc;
    else if (w_wr_hit && i_waddr == i_raddr2) o_rdata2 = i_wdata;
    else                                      o_rdata2 = r_regs[i_raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// ARM instruction-decode stage: decodes data-processing, memory and branch
// formats, gates them with the condition check, reads operands and registers
// the result into the ID/EX boundary.
module id_stage
  import arm_pkg::*;
#(
  parameter int NUM_REGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        hazard,
  input  logic [31:0] PC_in,
  input  logic [31:0] Instruction,
  input  logic [3:0]  SR,
  input  logic        WB_WB_EN,
  input  logic [3:0]  WB_Dest,
  input  logic [31:0] WB_Value,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        B,
  output logic        S,
  output logic [3:0]  EXE_CMD,
  output logic [31:0] Val_Rn,
  output logic [31:0] Val_Rm,
  output logic [31:0] PC,
  output logic        imm,
  output logic [11:0] Shift_operand,
  output logic [23:0] Signed_imm_24,
  output logic [3:0]  Dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        Two_src
);

  mode_e       w_mode;
  logic        w_i_bit;
  logic        w_s_bit;
  logic [3:0]  w_opcode;
  logic [3:0]  w_rn;
  logic [3:0]  w_rd;
  logic [3:0]  w_rm;
  logic        w_is_store;
  logic        w_cond_ok;
  logic [31:0] w_val_rn;
  logic [31:0] w_val_rm;
  ctrl_t       w_dec;
  ctrl_t       w_ctrl;
  idex_data_t  w_data;
  ctrl_t       r_ctrl;
  idex_data_t  r_data;

  assign w_mode    = mode_e'(Instruction[27:26]);
  assign w_i_bit   = Instruction[25];
  assign w_opcode  = Instruction[24:21];
  assign w_s_bit   = Instruction[20];
  assign w_rn      = Instruction[19:16];
  assign w_rd      = Instruction[15:12];
  assign w_rm      = Instruction[3:0];
  assign w_cond_ok = cond_pass(Instruction[31:28], SR);

  // The hazard unit needs the store's data register before the condition is
  // known, so the store decision here ignores the condition field.
  assign w_is_store = (w_mode == MODE_MEM) && !w_s_bit;
  assign src1       = w_rn;
  assign src2       = w_is_store ? w_rd : w_rm;
  assign Two_src    = (w_mode != MODE_BR) && (!w_i_bit || w_is_store);

  register_file #(
    .NUM_REGS(NUM_REGS)
  ) u_register_file (
    .clk      (clk),
    .rst      (rst),
    .i_we     (WB_WB_EN),
    .i_waddr  (WB_Dest),
    .i_wdata  (WB_Value),
    .i_raddr1 (src1),
    .i_raddr2 (src2),
    .i_pc     (PC_in),
    .o_rdata1 (w_val_rn),
    .o_rdata2 (w_val_rm)
  );

  // Format decode into execute controls, before the condition check
  always_comb begin
    w_dec = '0;
    case (w_mode)
      MODE_DP: begin
        w_dec.wb_en = 1'b1;
        w_dec.s     = w_s_bit;
        case (w_opcode)
          OP_MOV: w_dec.exe_cmd = EXE_MOV;
          OP_MVN: w_dec.exe_cmd = EXE_MVN;
          OP_ADD: w_dec.exe_cmd = EXE_ADD;
          OP_ADC: w_dec.exe_cmd = EXE_ADC;
          OP_SUB: w_dec.exe_cmd = EXE_SUB;
          OP_SBC: w_dec.exe_cmd = EXE_SBC;
          OP_AND: w_dec.exe_cmd = EXE_AND;
          OP_ORR: w_dec.exe_cmd = EXE_ORR;
          OP_EOR: w_dec.exe_cmd = EXE_EOR;
          OP_CMP: begin
            w_dec.exe_cmd = EXE_SUB;
            w_dec.wb_en   = 1'b0;
          end
          OP_TST: begin
            w_dec.exe_cmd = EXE_AND;
            w_dec.wb_en   = 1'b0;
          end
          default: w_dec = '0;
        endcase
      end
      MODE_MEM: begin
        w_dec.exe_cmd = EXE_ADD;
        if (w_s_bit) begin
          w_dec.wb_en    = 1'b1;
          w_dec.mem_r_en = 1'b1;
          w_dec.s        = 1'b1;
        end else begin
          w_dec.mem_w_en = 1'b1;
        end
      end
      MODE_BR: w_dec.b = 1'b1;
      default: w_dec = '0;
    endcase
  end

  // A failed condition kills every side effect but leaves the ALU command
  always_comb begin
    w_ctrl = w_dec;
    if (!w_cond_ok) begin
      w_ctrl.wb_en    = 1'b0;
      w_ctrl.mem_r_en = 1'b0;
      w_ctrl.mem_w_en = 1'b0;
      w_ctrl.b        = 1'b0;
      w_ctrl.s        = 1'b0;
    end
  end

  assign w_data = '{
    val_rn:        w_val_rn,
    val_rm:        w_val_rm,
    pc:            PC_in,
    imm:           w_i_bit,
    shift_operand: Instruction[11:0],
    signed_imm_24: Instruction[23:0],
    dest:          w_rd
  };

  // ID/EX register: flush beats freeze, freeze beats hazard bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (flush) begin
      r_ctrl <= '0;
      r_data <= w_data;
    end else if (!freeze) begin
      r_ctrl <= hazard ? '0 : w_ctrl;
      r_data <= w_data;
    end
  end

  assign WB_EN         = r_ctrl.wb_en;
  assign MEM_R_EN      = r_ctrl.mem_r_en;
  assign MEM_W_EN      = r_ctrl.mem_w_en;
  assign B             = r_ctrl.b;
  assign S             = r_ctrl.s;
  assign EXE_CMD       = r_ctrl.exe_cmd;
  assign Val_Rn        = r_data.val_rn;
  assign Val_Rm        = r_data.val_rm;
  assign PC            = r_data.pc;
  assign imm           = r_data.imm;
  assign Shift_operand = r_data.shift_operand;
  assign Signed_imm_24 = r_data.signed_imm_24;
  assign Dest          = r_data.dest;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the ARM pipeline, directly downstream of instruction fetch. It takes the fetched instruction and PC, reads operands from an internal 16-entry register file, and decodes the data-processing, memory and branch formats into execute-stage controls. It evaluates the condition field against the NZCV status and registers everything into the ID/EX boundary. The same register file receives write-back traffic from the last stage.

## Interface
Parameters:
- `NUM_REGS`, 15: writable general registers R0..R14; R15 reads as PC.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `freeze`  in  1  hold ID/EX register contents (downstream stall)
- `flush`  in  1  Branch_taken from execute; squash this cycle's decode
- `hazard`  in  1  insert bubble (load-use); fetch is frozen by the same signal
- `PC_in`  in  32  PC from IF (already +1, word-addressed)
- `Instruction`  in  32  fetched instruction
- `SR`  in  4  status flags {N,Z,C,V}
- `WB_WB_EN`  in  1  register-file write enable
- `WB_Dest`  in  4  write address
- `WB_Value`  in  32  write data
- `WB_EN, MEM_R_EN, MEM_W_EN, B, S`  out  1 each  registered controls
- `EXE_CMD`  out  4  registered ALU command
- `Val_Rn, Val_Rm, PC`  out  32 each  registered operands / PC
- `imm`  out  1  registered I bit
- `Shift_operand`  out  12  registered bits [11:0]
- `Signed_imm_24`  out  24  registered bits [23:0]
- `Dest`  out  4  registered Rd
- `src1, src2`  out  4 each  combinational (unregistered) source addresses for the hazard unit
- `Two_src`  out  1  combinational; the current instruction reads Rm/Rd as a second source

## Operation
- Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12].
- Mode 00 (data processing), opcode -> EXE_CMD:
  - MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011
  - SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111
  - EOR 0001->1000, CMP 1010->0100, TST 1000->0110
  - All write Rd (WB_EN=1) except CMP/TST.
  - Undefined opcodes produce all-zero controls.
- Mode 01 (memory): EXE_CMD=0010.
  - S=1 (LDR): WB_EN=1, MEM_R_EN=1.
  - S=0 (STR): MEM_W_EN=1, output S forced 0.
- Mode 10 (branch): B=1, all other controls 0.
- Condition:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1; 1111 never.
  - Failing condition zeroes WB_EN, MEM_R_EN, MEM_W_EN, B, S.
- Operand addresses and register file:
  - src1=Rn. src2 = MEM_W_EN ? Rd : Rm[3:0].
  - Two_src = !I | MEM_W_EN, forced 0 for branches.
  - Two read ports; address 15 returns PC_in.
  - Write on rising edge when WB_WB_EN and WB_Dest<15; writes to 15 are ignored.
  - Read of an address being written in the same cycle returns WB_Value (write-through).

## Timing
- Reset: all registers R0..R14 = 0. All ID/EX outputs = 0.
- Latency: 1 cycle, decode inputs at cycle n -> outputs after edge n.
- Priority per edge:
  1. `flush`: controls zeroed, data fields still captured.
  2. `freeze`: hold everything.
  3. `hazard`: controls zeroed, bubble.
  4. Otherwise capture.
- Register-file writes occur regardless of freeze, flush or hazard.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Structure
- Shared package `arm_pkg`:
  - EXE_CMD constants
  - mode encodings
  - condition-code enum
  - status-bit indices
- Sub-module `register_file`: 2R/1W, write-through, async reset.
- Condition check and decode stay inline in `id_stage`.

## Test plan
- Reset, then 0xE3A00014 (MOV R0,#20) with SR=0 -> next edge: WB_EN=1, EXE_CMD=0001, imm=1, Dest=0, Shift_operand=0x014, Two_src=0.
- Write R2=5, then 0xE0923002 (ADDS R3,R2,R2) -> Val_Rn=Val_Rm=5, EXE_CMD=0010, S=1, Dest=3. Also repeat with the write in the same cycle: write-through returns 5.
- 0xE4801000 (STR R1,[R0]) -> MEM_W_EN=1, WB_EN=0, src2=1, Two_src=1.
- 0xBAFFFFF7 (BLT): SR N=1,V=0 -> B=1, Signed_imm_24=0xFFFFF7. SR N=V=0 -> B=0, all controls 0.
- hazard=1 with ADD -> controls 0. freeze=1 -> outputs unchanged. flush and freeze together -> controls 0.
- WB_Dest=15, value 0xDEAD -> reading R15 returns PC_in. Async rst mid-stream -> all outputs 0 before the next edge.
